// File: rtl/multi_cycle_ctrl.sv
`timescale 1ns/1ps
// Multi-cycle MIPS-subset control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives datapath enables/selects, plus a retire pulse and a retired-instruction count.
//
// state  | meaning
// FETCH  | load instruction register
// DECODE | classify; j/jr/illegal finish here
// EXEC   | ALU operation; beq finishes here
// MEM    | data-memory access, stalls on mem_ready=0; sw finishes here
// WB     | register-file write
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [1:0]  zero,
  input  logic        mem_ready,
  output logic        ir_en,
  output logic        pc_en,
  output logic [2:0]  NPCop,
  output logic        reg_write,
  output logic [2:0]  reg_dst,
  output logic [2:0]  which_to_reg,
  output logic [1:0]  ALU_src,
  output logic [4:0]  ALU_op,
  output logic        sign,
  output logic        mem_write,
  output logic [1:0]  LS_op,
  output logic [2:0]  state,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] retired_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [31:0] cnt_q;

  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  logic       ir_c, fin_c, rw_c, mw_c, ill_c, alu_phase;
  logic [2:0] npc_c, dst_c, wtr_c;
  logic [1:0] alu_src_c;
  logic [4:0] alu_op_c;
  logic       sign_c;
  logic       unused_zero_hi;

  assign unused_zero_hi = zero[1];

  assign is_rtype = (opcode == 6'b000000);
  assign is_addu  = is_rtype && (func == 6'b100001);
  assign is_subu  = is_rtype && (func == 6'b100011);
  assign is_jr    = is_rtype && (func == 6'b001000);
  assign is_ori   = (opcode == 6'b001101);
  assign is_lui   = (opcode == 6'b001111);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_j     = (opcode == 6'b000010);
  assign is_jal   = (opcode == 6'b000011);
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw |
                    is_sw | is_beq | is_j | is_jal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = FETCH;
    ir_c      = 1'b0;
    fin_c     = 1'b0;
    rw_c      = 1'b0;
    mw_c      = 1'b0;
    ill_c     = 1'b0;
    alu_phase = 1'b0;
    npc_c     = 3'd0;
    dst_c     = 3'd0;
    wtr_c     = 3'd0;
    case (state_q)
      FETCH: begin
        ir_c    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (!is_legal) begin
          ill_c = 1'b1;
          fin_c = 1'b1;
        end else if (is_j) begin
          fin_c = 1'b1;
          npc_c = 3'd2;
        end else if (is_jr) begin
          fin_c = 1'b1;
          npc_c = 3'd3;
        end else if (is_jal) begin
          state_d = WB;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_phase = 1'b1;
        if (is_lw || is_sw) begin
          state_d = MEM;
        end else if (is_beq) begin
          fin_c = 1'b1;
          npc_c = zero[0] ? 3'd1 : 3'd0;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        alu_phase = 1'b1;
        if (!mem_ready) begin
          state_d = MEM;
        end else if (is_lw) begin
          state_d = WB;
        end else if (is_sw) begin
          mw_c  = 1'b1;
          fin_c = 1'b1;
        end
      end
      WB: begin
        alu_phase = 1'b1;
        rw_c      = 1'b1;
        fin_c     = 1'b1;
        if (is_jal) begin
          dst_c = 3'd2;
          wtr_c = 3'd2;
          npc_c = 3'd2;
        end else if (is_lw) begin
          dst_c = 3'd1;
          wtr_c = 3'd1;
        end else if (is_ori || is_lui) begin
          dst_c = 3'd1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU controls are a pure function of the opcode, so they stay put across a MEM stall.
  always_comb begin
    alu_src_c = 2'd0;
    alu_op_c  = 5'd0;
    sign_c    = 1'b0;
    if (alu_phase) begin
      if (is_subu || is_beq) begin
        alu_op_c = 5'd1;
      end else if (is_ori) begin
        alu_src_c = 2'd1;
        alu_op_c  = 5'd2;
      end else if (is_lui) begin
        alu_src_c = 2'd1;
        alu_op_c  = 5'd3;
      end else if (is_lw || is_sw) begin
        alu_src_c = 2'd1;
        sign_c    = 1'b1;
      end
    end
  end

  // Enables are masked by reset so an abandoned instruction commits nothing.
  assign ir_en        = ir_c  & ~reset;
  assign pc_en        = fin_c & ~reset;
  assign retire       = fin_c & ~reset;
  assign reg_write    = rw_c  & ~reset;
  assign mem_write    = mw_c  & ~reset;
  assign illegal      = ill_c & ~reset;
  assign NPCop        = npc_c;
  assign reg_dst      = dst_c;
  assign which_to_reg = wtr_c;
  assign ALU_src      = alu_src_c;
  assign ALU_op       = alu_op_c;
  assign sign         = sign_c;
  assign LS_op        = 2'd0;
  assign state        = state_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for multi_cycle_ctrl: per-instruction cycle paths derived from the
// instruction class feed an expectation queue; a negedge monitor compares every cycle.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, func;
  logic [1:0]  zero;
  logic        mem_ready;
  logic        ir_en, pc_en, reg_write, sign, mem_write, retire, illegal;
  logic [2:0]  NPCop, reg_dst, which_to_reg, state;
  logic [1:0]  ALU_src, LS_op;
  logic [4:0]  ALU_op;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .ir_en(ir_en), .pc_en(pc_en), .NPCop(NPCop),
    .reg_write(reg_write), .reg_dst(reg_dst), .which_to_reg(which_to_reg),
    .ALU_src(ALU_src), .ALU_op(ALU_op), .sign(sign), .mem_write(mem_write),
    .LS_op(LS_op), .state(state), .retire(retire), .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_en;
    logic        pc_en;
    logic [2:0]  npc;
    logic        reg_write;
    logic [2:0]  reg_dst;
    logic [2:0]  wtr;
    logic [1:0]  alu_src;
    logic [4:0]  alu_op;
    logic        sign;
    logic        mem_write;
    logic [1:0]  ls_op;
    logic        retire;
    logic        illegal;
    logic [31:0] cnt;
  } obs_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
  localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  obs_t        exp_q[$];
  obs_t        care_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_cnt;

  function automatic bit legal_enc(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) return (fn inside {6'b100001, 6'b100011, 6'b001000});
    return (op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100,
                       6'b000010, 6'b000011});
  endfunction

  task automatic encode(input int kind, input int variant,
                        output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    op = 6'd0;
    case (kind)
      K_ADDU: fn = 6'b100001;
      K_SUBU: fn = 6'b100011;
      K_JR:   fn = 6'b001000;
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        if (variant == 0) op = 6'b111111;
        else begin
          do begin
            op = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            fn = 6'($urandom);
          end while (legal_enc(op, fn));
        end
      end
    endcase
  endtask

  function automatic obs_t expect_cycle(input int kind, input int s, input bit fin,
                                        input logic [1:0] z, input bit mr,
                                        input logic [31:0] cnt);
    obs_t e;
    e         = '0;
    e.st      = 3'(s);
    e.ir_en   = (s == 0);
    e.pc_en   = fin;
    e.retire  = fin;
    e.illegal = fin && (kind == K_ILL);
    e.cnt     = cnt;
    if (fin) begin
      if (kind == K_J || kind == K_JAL) e.npc = 3'd2;
      else if (kind == K_JR)            e.npc = 3'd3;
      else if (kind == K_BEQ)           e.npc = z[0] ? 3'd1 : 3'd0;
    end
    if (s == 4) begin
      e.reg_write = 1'b1;
      if (kind == K_JAL) begin e.reg_dst = 3'd2; e.wtr = 3'd2; end
      if (kind == K_LW)  begin e.reg_dst = 3'd1; e.wtr = 3'd1; end
      if (kind == K_ORI || kind == K_LUI) e.reg_dst = 3'd1;
    end
    if (s >= 2 && s <= 4) begin
      case (kind)
        K_SUBU, K_BEQ: e.alu_op = 5'd1;
        K_ORI:         begin e.alu_src = 2'd1; e.alu_op = 5'd2; end
        K_LUI:         begin e.alu_src = 2'd1; e.alu_op = 5'd3; end
        K_LW, K_SW:    begin e.alu_src = 2'd1; e.sign = 1'b1; end
        default: ;
      endcase
    end
    e.mem_write = (s == 3) && (kind == K_SW) && mr;
    return e;
  endfunction

  // One instruction: the cycle path follows from its class and the chosen MEM stalls.
  task automatic run_instr(input int kind, input int stalls, input int abort_at,
                           input int zval, input int variant);
    int          path[$];
    logic [5:0]  op, fn;
    int          m;
    obs_t        e, c;
    bit          fin, ab, mr;
    logic [1:0]  z;
    encode(kind, variant, op, fn);
    path = {0, 1};
    case (kind)
      K_J, K_JR, K_ILL: ;
      K_JAL: path.push_back(4);
      K_BEQ: path.push_back(2);
      K_LW, K_SW: begin
        path.push_back(2);
        repeat (stalls + 1) path.push_back(3);
        if (kind == K_LW) path.push_back(4);
      end
      default: begin path.push_back(2); path.push_back(4); end
    endcase
    m = 0;
    for (int i = 0; i < path.size(); i++) begin
      fin = (i == path.size() - 1);
      ab  = (i == abort_at);
      if (path[i] == 0) begin
        opcode = 6'($urandom);
        func   = 6'($urandom);
      end else begin
        opcode = op;
        func   = fn;
      end
      z = (zval >= 0 && path[i] == 2) ? 2'(zval) : 2'($urandom);
      if (path[i] == 3) begin
        mr = (m == stalls);
        m++;
      end else begin
        mr = 1'($urandom);
      end
      zero      = z;
      mem_ready = mr;
      reset     = ab;
      e = expect_cycle(kind, path[i], fin, z, mr, model_cnt);
      c = '1;
      if (ab) begin
        e.ir_en = 0; e.pc_en = 0; e.reg_write = 0; e.mem_write = 0;
        e.retire = 0; e.illegal = 0;
        c = '0;
        c.st = '1; c.ir_en = 1; c.pc_en = 1; c.reg_write = 1;
        c.mem_write = 1; c.retire = 1; c.illegal = 1;
      end
      exp_q.push_back(e);
      care_q.push_back(c);
      @(posedge clk); #1;
      if (ab) begin
        model_cnt = 32'd0;
        return;
      end
    end
    model_cnt = model_cnt + 32'd1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, c, g;
      e = exp_q.pop_front();
      c = care_q.pop_front();
      g = {state, ir_en, pc_en, NPCop, reg_write, reg_dst, which_to_reg, ALU_src,
           ALU_op, sign, mem_write, LS_op, retire, illegal, retired_cnt};
      vectors++;
      if (((g ^ e) & c) != '0) begin
        miscompares++;
        $display("FAIL cycle_outputs vec %0d: got %h required %h (care %h)",
                 vectors, g, e, c);
      end
    end
  end

  initial begin
    int k, st, ab;
    reset = 1'b1; opcode = 6'd0; func = 6'd0; zero = 2'd0; mem_ready = 1'b0;
    model_cnt = 32'd0;
    @(posedge clk); #1;
    begin
      obs_t e0;
      e0 = '0;
      exp_q.push_back(e0);
      care_q.push_back('1);
    end
    @(posedge clk); #1;

    run_instr(K_ADDU, 0, -1, -1, 0);
    run_instr(K_LW,   3, -1, -1, 0);
    run_instr(K_BEQ,  0, -1,  1, 0);
    run_instr(K_BEQ,  0, -1,  0, 0);
    run_instr(K_JAL,  0, -1, -1, 0);
    run_instr(K_JR,   0, -1, -1, 0);
    run_instr(K_ILL,  0, -1, -1, 0);
    run_instr(K_SW,   0,  3, -1, 0);
    run_instr(K_ORI,  0, -1, -1, 0);
    run_instr(K_SW,   2, -1, -1, 0);

    repeat (300) begin
      k  = $urandom_range(0, 10);
      st = $urandom_range(0, 3);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : -1;
      run_instr(k, st, ab, -1, 1);
    end

    reset = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 opcode  in  6  instr[31:26] from the datapath instruction register; valid from DECODE onward.
REQ-004 func  in  6  instr[5:0]; meaningful only when opcode == 000000.
REQ-005 zero  in  2  ALU equality flag; zero[0]=1 means A==B, zero[1] is ignored.
REQ-006 mem_ready  in  1  data-memory handshake; 1 = access completes this cycle.
REQ-007 ir_en  out  1  instruction-register load enable.
REQ-008 pc_en  out  1  PC load enable; PC takes NPC at the edge.
REQ-009 NPCop  out  3  0 = PC+4, 1 = beq target, 2 = j/jal imm26, 3 = jr (rs register).
REQ-010 reg_write  out  1  GRF write enable.
REQ-011 reg_dst  out  3  0 = rd, 1 = rt, 2 = $31.
REQ-012 which_to_reg  out  3  0 = ALU result, 1 = DM read data, 2 = PC+4.
REQ-013 ALU_src  out  2  0 = RD2, 1 = extended imm32.
REQ-014 ALU_op  out  5  0 = add, 1 = sub, 2 = or, 3 = lui (B<<16).
REQ-015 sign  out  1  EXT mode; 1 = sign-extend, 0 = zero-extend.
REQ-016 mem_write  out  1  DM write enable.
REQ-017 LS_op  out  2  fixed at 0 (word access).
REQ-018 state  out  3  current FSM state encoding.
REQ-019 retire  out  1  one-cycle pulse when an instruction completes.
REQ-020 illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode or func.
REQ-021 retired_cnt  out  32  count of completed instructions, including illegal ones.

Function
REQ-022 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; all other encodings SHALL go to FETCH on the next edge.
REQ-023 Supported instructions SHALL be:
- R-type addu (func 100001), subu (func 100011), jr (func 001000)
- ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011
REQ-024 FETCH: ir_en=1; next state is DECODE.
REQ-025 DECODE transitions:
- j / jr: next state FETCH.
- jal: next state WB.
- illegal: next state FETCH.
- all others: next state EXEC.
REQ-026 EXEC transitions:
- lw / sw: next state MEM.
- beq: next state FETCH.
- others: next state WB.
REQ-027 MEM:
- while mem_ready=0, state SHALL hold with all outputs stable.
- when mem_ready=1: lw goes to WB; sw goes to FETCH.
REQ-028 WB: next state is FETCH.
REQ-029 Cycle counts, with mem_ready tied to 1:
- 2: j, jr, illegal
- 3: beq, jal
- 4: addu, subu, ori, lui, sw
- 5: lw
REQ-030 pc_en and retire SHALL be 1 only in the final cycle of each instruction.
- NPCop SHALL be 1 in that cycle only for beq with zero[0]=1; beq with zero[0]=0 uses NPCop=0.
- NPCop SHALL be 2 for j/jal, 3 for jr, and 0 otherwise.
REQ-031 reg_write SHALL be 1 only in WB.
- addu / subu: reg_dst=0, which_to_reg=0.
- ori / lui: reg_dst=1, which_to_reg=0.
- lw: reg_dst=1, which_to_reg=1.
- jal: reg_dst=2, which_to_reg=2.
REQ-032 mem_write SHALL be 1 only in MEM for sw, in the cycle where mem_ready=1.
REQ-033 From EXEC through WB, ALU_src, ALU_op and sign SHALL be held constant per instruction:
- addu: ALU_src=0, ALU_op=0.
- subu: ALU_src=0, ALU_op=1.
- beq: ALU_src=0, ALU_op=1.
- ori: ALU_src=1, ALU_op=2, sign=0.
- lui: ALU_src=1, ALU_op=3.
- lw / sw: ALU_src=1, ALU_op=0, sign=1.
REQ-034 Every enable not named for a state SHALL be 0 in that state; data-select outputs not named SHALL be 0.
REQ-035 retired_cnt SHALL increment by 1 on every retire pulse and wrap from FFFFFFFF to 0.
REQ-036 illegal SHALL pulse in the DECODE cycle together with retire and pc_en (NPCop=0), so that the instruction is skipped.

Reset
REQ-037 While reset=1: next state is FETCH, retired_cnt is 0, and all enables (ir_en, pc_en, reg_write, mem_write, retire, illegal) SHALL be 0 in that cycle.
REQ-038 Reset asserted mid-instruction (any state, including MEM stall) SHALL abandon the instruction with no PC, GRF or DM update and no retire pulse.

Verification
REQ-039 Reset, then addu with mem_ready=1:
- state sequence 0,1,2,4,0.
- reg_write=1 and pc_en=1 only in cycle 4.
- retired_cnt=1 afterwards.
REQ-040 lw with mem_ready low for 3 MEM cycles:
- state sequence 0,1,2,3,3,3,3,4.
- mem_write=0 throughout; which_to_reg=1 in WB.
- total 8 cycles.
REQ-041 beq with zero=01 gives NPCop=1 and pc_en=1 in EXEC; beq with zero=00 gives NPCop=0; both take 3 cycles.
REQ-042 jal then jr:
- jal WB cycle: reg_dst=2, which_to_reg=2, NPCop=2.
- jr DECODE cycle: NPCop=3, pc_en=1.
- retired_cnt advances by 2.
REQ-043 opcode 111111 gives illegal=1 and retire=1 in DECODE, with no reg_write or mem_write.
REQ-044 reset asserted in the first MEM cycle of an sw: no mem_write, FETCH next, retired_cnt=0.
